// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, function
// codes, ALU operations, FSM state codes and datapath select values.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_PASS = 4'b0110;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_IMM_EXEC  = 4'd10;
  localparam logic [3:0] S_IMM_WB    = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Which flavour of ALU control the current state wants.
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ADD,
    CLS_RTYPE,
    CLS_IMM,
    CLS_IMM_WB,
    CLS_BRANCH,
    CLS_JUMP
  } alu_class_t;

  function automatic logic is_logical_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// Maps the state's ALU class plus op_code/func onto the ALU operation and the
// immediate extension mode.
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] func,
  input  alu_class_t alu_class,
  output logic [3:0] alu_op,
  output logic       ext_zero
);

  always_comb begin
    alu_op   = ALU_ADD;
    ext_zero = 1'b0;
    case (alu_class)
      CLS_ADD: alu_op = ALU_ADD;
      CLS_RTYPE: begin
        case (func)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_SUB;
        endcase
      end
      CLS_IMM: begin
        case (op_code)
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
        ext_zero = is_logical_imm(op_code);
      end
      // Writeback keeps the extension mode steady while the ALU op drops to 0.
      CLS_IMM_WB: ext_zero = is_logical_imm(op_code);
      CLS_BRANCH: alu_op = ALU_SUB;
      CLS_JUMP:   alu_op = ALU_PASS;
      default: begin
        alu_op   = ALU_ADD;
        ext_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic and
// Moore output decode for the shared memory/ALU datapath.
//
// state       | meaning
// ------------+-----------------------------------------------
// FETCH       | read instruction at PC, PC+4, wait on mem_ready
// DECODE      | branch target into ALUOut, dispatch on op_code
// MEM_ADDR    | effective address A + sext(imm)
// MEM_READ    | load data read, wait on mem_ready
// MEM_WB      | load result into register file
// MEM_WRITE   | store data write, wait on mem_ready
// EXECUTE     | R-type ALU operation
// R_WB        | R-type result into rd
// BRANCH      | compare A/B, conditionally load PC from ALUOut
// JUMP        | load PC with jump target
// IMM_EXEC    | immediate ALU operation
// IMM_WB      | immediate result into rt
// TRAP        | illegal opcode, held until reset
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_code,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       illegal
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  alu_class_t alu_class;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LW, OP_SW:                      state_nxt = S_MEM_ADDR;
          OP_RTYPE:                          state_nxt = S_EXECUTE;
          OP_BEQ, OP_BNE:                    state_nxt = S_BRANCH;
          OP_J:                              state_nxt = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_nxt = S_IMM_EXEC;
          default:                           state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_nxt = (op_code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_nxt = S_FETCH;
      S_EXECUTE:   state_nxt = S_R_WB;
      S_R_WB:      state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_JUMP:      state_nxt = S_FETCH;
      S_IMM_EXEC:  state_nxt = S_IMM_WB;
      S_IMM_WB:    state_nxt = S_FETCH;
      S_TRAP:      state_nxt = S_TRAP;
      default:     state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_source  = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    alu_class  = CLS_NONE;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_class = CLS_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_class = CLS_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_class = CLS_ADD;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_class = CLS_RTYPE;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_class = CLS_BRANCH;
        pc_source = PCSRC_ALUOUT;
        pc_en     = (op_code == OP_BNE) ? ~zero : zero;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
        alu_class = CLS_JUMP;
        retire    = 1'b1;
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_class = CLS_IMM;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        alu_class = CLS_IMM_WB;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    // Reset silences the datapath at once, even mid memory wait.
    if (rst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_source  = PCSRC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REGB;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      alu_class  = CLS_NONE;
    end
  end

  alu_op_decode u_alu_op_decode (
    .op_code   (op_code),
    .func      (func),
    .alu_class (alu_class),
    .alu_op    (alu_op),
    .ext_zero  (ext_zero)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, hand-written
// wait/reset/trap sequences and a randomized run against an instruction-level model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] op_code = 6'b0;
  logic [5:0] func = 6'b0;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_en;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [3:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, retire, illegal;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op_code(op_code), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mr, mw, iod, irw, pce;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic       ez;
    logic [3:0] aop;
    logic       rw, rd, m2r, ret, ill;
  } out_t;

  out_t act;
  assign act = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
                alu_src_b, ext_zero, alu_op, reg_write, reg_dst, mem_to_reg, retire, illegal};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, a, e);
  endtask

  task automatic step(input logic r, input logic z, input logic rdy,
                      input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    rst = r; zero = z; mem_ready = rdy; op_code = op; func = fn;
    #1;
  endtask

  function automatic out_t fetch_out(input logic rdy);
    out_t o;
    o = '0; o.mr = 1'b1; o.asb = 2'b01; o.irw = rdy; o.pce = rdy;
    return o;
  endfunction

  // Instruction-level reference: each instruction expands into a list of steps.
  typedef struct {
    out_t base;
    bit   waits;
    out_t rdy_bits;
    bit   br;
    bit   bne;
    bit   fetch;
  } phase_t;

  phase_t q[$];

  function automatic phase_t ph(input out_t b);
    phase_t p;
    p.base = b; p.waits = 1'b0; p.rdy_bits = '0; p.br = 1'b0; p.bne = 1'b0; p.fetch = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'd0;
      6'b100010: return 4'd1;
      6'b100100: return 4'd2;
      6'b100101: return 4'd3;
      6'b100110: return 4'd4;
      6'b101010: return 4'd5;
      default:   return 4'd1;
    endcase
  endfunction

  function automatic void build(input logic [5:0] op, input logic [5:0] fn);
    out_t o;
    phase_t p;
    logic lz;
    o = fetch_out(1'b0); p = ph(o); p.waits = 1'b1; p.fetch = 1'b1;
    p.rdy_bits.irw = 1'b1; p.rdy_bits.pce = 1'b1; q.push_back(p);
    o = '0; o.asb = 2'b11; q.push_back(ph(o));
    lz = (op == 6'b001100) || (op == 6'b001101);
    case (op)
      6'b100011, 6'b101011: begin
        o = '0; o.asa = 1'b1; o.asb = 2'b10; q.push_back(ph(o));
        if (op == 6'b100011) begin
          o = '0; o.mr = 1'b1; o.iod = 1'b1; p = ph(o); p.waits = 1'b1; q.push_back(p);
          o = '0; o.rw = 1'b1; o.m2r = 1'b1; o.ret = 1'b1; q.push_back(ph(o));
        end else begin
          o = '0; o.mw = 1'b1; o.iod = 1'b1; p = ph(o); p.waits = 1'b1;
          p.rdy_bits.ret = 1'b1; q.push_back(p);
        end
      end
      6'b000000: begin
        o = '0; o.asa = 1'b1; o.aop = r_alu(fn); q.push_back(ph(o));
        o = '0; o.rw = 1'b1; o.rd = 1'b1; o.ret = 1'b1; q.push_back(ph(o));
      end
      6'b000100, 6'b000101: begin
        o = '0; o.asa = 1'b1; o.aop = 4'd1; o.pcs = 2'b01; o.ret = 1'b1;
        p = ph(o); p.br = 1'b1; p.bne = op[0]; q.push_back(p);
      end
      6'b000010: begin
        o = '0; o.pcs = 2'b10; o.pce = 1'b1; o.aop = 4'd6; o.ret = 1'b1; q.push_back(ph(o));
      end
      default: begin
        o = '0; o.asa = 1'b1; o.asb = 2'b10; o.ez = lz;
        o.aop = (op == 6'b001010) ? 4'd5 : (op == 6'b001100) ? 4'd2 :
                (op == 6'b001101) ? 4'd3 : 4'd0;
        q.push_back(ph(o));
        o = '0; o.rw = 1'b1; o.ret = 1'b1; o.ez = lz; q.push_back(ph(o));
      end
    endcase
  endfunction

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cyc;
    int         pcen;
    logic [3:0] aop3;
    logic       ez3;
  } vec_t;

  vec_t tbl[18];
  logic [5:0] ops[10];
  logic [5:0] fns[6];

  initial begin
    tbl[0]  = '{6'b000000, 6'b100110, 1'b0, 4, 0, 4'b0100, 1'b0};
    tbl[1]  = '{6'b000000, 6'b111111, 1'b0, 4, 0, 4'b0001, 1'b0};
    tbl[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 0, 4'b0000, 1'b0};
    tbl[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 0, 4'b0001, 1'b0};
    tbl[4]  = '{6'b000000, 6'b100100, 1'b0, 4, 0, 4'b0010, 1'b0};
    tbl[5]  = '{6'b000000, 6'b100101, 1'b0, 4, 0, 4'b0011, 1'b0};
    tbl[6]  = '{6'b000000, 6'b101010, 1'b0, 4, 0, 4'b0101, 1'b0};
    tbl[7]  = '{6'b100011, 6'b000000, 1'b0, 5, 0, 4'b0000, 1'b0};
    tbl[8]  = '{6'b101011, 6'b000000, 1'b0, 4, 0, 4'b0000, 1'b0};
    tbl[9]  = '{6'b000100, 6'b000000, 1'b1, 3, 1, 4'b0001, 1'b0};
    tbl[10] = '{6'b000100, 6'b000000, 1'b0, 3, 0, 4'b0001, 1'b0};
    tbl[11] = '{6'b000101, 6'b000000, 1'b1, 3, 0, 4'b0001, 1'b0};
    tbl[12] = '{6'b000101, 6'b000000, 1'b0, 3, 1, 4'b0001, 1'b0};
    tbl[13] = '{6'b000010, 6'b000000, 1'b0, 3, 1, 4'b0110, 1'b0};
    tbl[14] = '{6'b001000, 6'b000000, 1'b0, 4, 0, 4'b0000, 1'b0};
    tbl[15] = '{6'b001010, 6'b000000, 1'b0, 4, 0, 4'b0101, 1'b0};
    tbl[16] = '{6'b001100, 6'b000000, 1'b0, 4, 0, 4'b0010, 1'b1};
    tbl[17] = '{6'b001101, 6'b000000, 1'b0, 4, 0, 4'b0011, 1'b1};
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b000010, 6'b001000, 6'b001010, 6'b001100, 6'b001101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};

    // Reset, then reset again in the middle of a store's memory wait.
    step(1'b1, 1'b0, 1'b0, 6'b0, 6'b0);
    step(1'b1, 1'b0, 1'b0, 6'b0, 6'b0);
    chk("reset_outputs", 32'(act), 32'(out_t'('0)));
    step(1'b0, 1'b0, 1'b0, 6'b101011, 6'b0);
    chk("first_fetch", 32'(act), 32'(fetch_out(1'b0)));
    step(1'b0, 1'b0, 1'b1, 6'b101011, 6'b0);
    chk("fetch_ready", 32'(act), 32'(fetch_out(1'b1)));
    step(1'b0, 1'b0, 1'b0, 6'b101011, 6'b0);
    step(1'b0, 1'b0, 1'b0, 6'b101011, 6'b0);
    step(1'b0, 1'b0, 1'b0, 6'b101011, 6'b0);
    chk("sw_wait_mw", 32'(mem_write), 32'd1);
    chk("sw_wait_noretire", 32'(retire), 32'd0);
    step(1'b1, 1'b0, 1'b0, 6'b101011, 6'b0);
    chk("rst_in_wait_1", 32'(act), 32'(out_t'('0)));
    step(1'b1, 1'b0, 1'b0, 6'b101011, 6'b0);
    chk("rst_in_wait_2", 32'(act), 32'(out_t'('0)));
    step(1'b0, 1'b0, 1'b0, 6'b0, 6'b0);
    chk("fetch_after_rst", 32'(act), 32'(fetch_out(1'b0)));

    // Directed table, mem_ready held high.
    foreach (tbl[k]) begin
      int cyc;
      int pcen;
      logic [3:0] a3;
      logic e3;
      cyc = 0; pcen = 0; a3 = 4'hf; e3 = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        step(1'b0, tbl[k].z, 1'b1, tbl[k].op, tbl[k].fn);
        if (c == 3) begin a3 = alu_op; e3 = ext_zero; end
        if (c > 1 && pc_en) pcen++;
        if (retire) begin cyc = c; break; end
      end
      chk($sformatf("tbl%0d_cycles", k), 32'(cyc), 32'(tbl[k].cyc));
      chk($sformatf("tbl%0d_pc_en", k), 32'(pcen), 32'(tbl[k].pcen));
      chk($sformatf("tbl%0d_alu_op", k), 32'(a3), 32'(tbl[k].aop3));
      chk($sformatf("tbl%0d_ext_zero", k), 32'(e3), 32'(tbl[k].ez3));
    end

    // Load with three wait cycles in the memory-read step: 8 cycles total.
    step(1'b0, 1'b0, 1'b1, 6'b100011, 6'b0);
    step(1'b0, 1'b0, 1'b0, 6'b100011, 6'b0);
    step(1'b0, 1'b0, 1'b0, 6'b100011, 6'b0);
    chk("lw_addr_srcb", 32'(alu_src_b), 32'd2);
    for (int w = 0; w < 4; w++) begin
      step(1'b0, 1'b1, (w == 3), 6'b100011, 6'b0);
      chk($sformatf("lw_wait%0d_strobes", w), 32'({mem_read, i_or_d, retire}), 32'b110);
    end
    step(1'b0, 1'b0, 1'b0, 6'b100011, 6'b0);
    chk("lw_wb", 32'({reg_write, mem_to_reg, retire}), 32'b111);

    // Randomized run against the instruction-level model.
    q.delete();
    begin
      logic [5:0] cur_op;
      logic [5:0] cur_fn;
      cur_op = 6'b0; cur_fn = 6'b0;
      for (int i = 0; i < 600; i++) begin
        phase_t h;
        out_t   e;
        logic   r;
        logic   z;
        if (q.size() == 0) begin
          cur_op = ops[$urandom_range(0, 9)];
          cur_fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
          build(cur_op, cur_fn);
        end
        h = q[0];
        r = ($urandom_range(0, 2) != 0);
        z = 1'($urandom_range(0, 1));
        if (h.fetch) step(1'b0, z, r, 6'($urandom), 6'($urandom));
        else         step(1'b0, z, r, cur_op, cur_fn);
        e = h.base | ((h.waits && r) ? h.rdy_bits : out_t'('0));
        if (h.br) e.pce = z ^ h.bne;
        chk($sformatf("rand%0d", i), 32'(act), 32'(e));
        if (!h.waits || r) void'(q.pop_front());
      end
    end

    // Illegal opcode traps on the third cycle and stays there until reset.
    step(1'b1, 1'b0, 1'b0, 6'b0, 6'b0);
    step(1'b0, 1'b0, 1'b1, 6'b111111, 6'b0);
    step(1'b0, 1'b0, 1'b1, 6'b111111, 6'b0);
    chk("trap_decode_clear", 32'(illegal), 32'd0);
    for (int t = 0; t < 20; t++) begin
      out_t e;
      e = '0; e.ill = 1'b1;
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom));
      chk($sformatf("trap%0d", t), 32'(act), 32'(e));
    end
    step(1'b1, 1'b0, 1'b0, 6'b0, 6'b0);
    chk("trap_rst_clear", 32'(illegal), 32'd0);
    step(1'b0, 1'b0, 1'b0, 6'b0, 6'b0);
    chk("trap_fetch_after_rst", 32'(act), 32'(fetch_out(1'b0)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
